// File: rtl/mem_arbiter_n.sv
// Multi-channel memory arbiter: grants one request at a time and moves 1/2/4 bytes over an 8-bit bus.
// Define MEM_ARB_RR_EN for round-robin grant; otherwise fixed priority with the lowest index winning.
//
// state | meaning
// IDLE  | no transfer in flight; grant decided here; done pulses land here
// ADDR  | bus carries address of byte k (and write data); read bytes k-1 captured
// TAIL  | read only: capture final byte, then done with rdata
module mem_arbiter_n #(
  parameter int NCH    = 3,
  parameter int ADDR_W = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      req,
  input  logic [NCH-1:0]      we,
  input  logic [2*NCH-1:0]    size,
  input  logic [32*NCH-1:0]   addr,
  input  logic [32*NCH-1:0]   wdata,
  output logic [31:0]         rdata,
  output logic [NCH-1:0]      done,
  output logic                busy,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [31:0]         mem_a,
  output logic                mem_wr
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, ADDR, TAIL} state_t;
  state_t state, state_nx;

  logic [31:0] addr_a  [NCH];
  logic [31:0] wdata_a [NCH];
  logic [1:0]  size_a  [NCH];
  logic        unused_hi;

  always_comb begin
    unused_hi = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      addr_a[i]  = addr[32*i +: 32];
      wdata_a[i] = wdata[32*i +: 32];
      size_a[i]  = size[2*i +: 2];
      unused_hi  = unused_hi ^ (^addr_a[i][31:ADDR_W]);
    end
  end

  // A channel finishing this cycle must not be re-granted before it drops req.
  logic [NCH-1:0] elig;
  logic           gnt_vld;
  logic [CW-1:0]  gnt_ch;
  assign elig = req & ~done;

`ifdef MEM_ARB_RR_EN
  logic [CW-1:0] rr_ptr;
  always_comb begin
    logic [CW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    // Descending scan with overwrite leaves the channel right after rr_ptr as winner.
    for (int i = NCH; i >= 1; i--) begin
      cand = CW'((int'(rr_ptr) + i) % NCH);
      if (elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            rr_ptr <= CW'(NCH-1);
    else if (state == IDLE && gnt_vld)   rr_ptr <= gnt_ch;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (elig[CW'(i)]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CW'(i);
      end
    end
  end
`endif

  logic [CW-1:0]     ch_q,   ch_d;
  logic              we_q,   we_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        k_q,    k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [31:0]       rbuf_q, rbuf_d;

  logic [31:0]    mem_a_d, rdata_d;
  logic [7:0]     mem_dout_d;
  logic           mem_wr_d, busy_d;
  logic [NCH-1:0] done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_vld) state_nx = ADDR;
      ADDR:    if (k_q == last_q) state_nx = we_q ? IDLE : TAIL;
      TAIL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    logic [1:0]        k_nx;
    logic [ADDR_W-1:0] a_nx;
    logic [31:0]       wsh;
    logic [1:0]        g_size;
    logic [31:0]       g_addr, g_wdata;

    ch_d       = ch_q;
    we_d       = we_q;
    last_d     = last_q;
    k_d        = k_q;
    base_d     = base_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a;
    mem_dout_d = mem_dout;
    mem_wr_d   = 1'b0;
    done_d     = '0;
    rdata_d    = rdata;
    k_nx       = k_q + 2'd1;
    a_nx       = base_q + ADDR_W'(k_nx);
    wsh        = wbuf_q >> {k_nx, 3'b000};
    g_size     = size_a[gnt_ch];
    g_addr     = addr_a[gnt_ch];
    g_wdata    = wdata_a[gnt_ch];

    case (state)
      IDLE: begin
        if (gnt_vld) begin
          ch_d       = gnt_ch;
          we_d       = we[gnt_ch];
          last_d     = (g_size == 2'd0) ? 2'd0 : (g_size == 2'd1) ? 2'd1 : 2'd3;
          k_d        = 2'd0;
          base_d     = g_addr[ADDR_W-1:0];
          wbuf_d     = g_wdata;
          rbuf_d     = '0;
          mem_a_d    = 32'(g_addr[ADDR_W-1:0]);
          mem_wr_d   = we[gnt_ch];
          mem_dout_d = we[gnt_ch] ? g_wdata[7:0] : mem_dout;
        end
      end
      ADDR: begin
        // Memory answers one cycle late, so this cycle's mem_din is byte k-1.
        if (!we_q && k_q != 2'd0) begin
          for (int b = 0; b < 4; b++)
            if (2'(b) == k_q - 2'd1) rbuf_d[8*b +: 8] = mem_din;
        end
        if (k_q != last_q) begin
          k_d        = k_nx;
          mem_a_d    = 32'(a_nx);
          mem_wr_d   = we_q;
          mem_dout_d = we_q ? wsh[7:0] : mem_dout;
        end else if (we_q) begin
          done_d = NCH'(1) << ch_q;
        end
      end
      TAIL: begin
        for (int b = 0; b < 4; b++)
          if (2'(b) == last_q) rbuf_d[8*b +: 8] = mem_din;
        rdata_d = rbuf_d;
        done_d  = NCH'(1) << ch_q;
      end
      default: ;
    endcase
    busy_d = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q     <= '0;
      we_q     <= 1'b0;
      last_q   <= 2'd0;
      k_q      <= 2'd0;
      base_q   <= '0;
      wbuf_q   <= '0;
      rbuf_q   <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      done     <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      we_q     <= we_d;
      last_q   <= last_d;
      k_q      <= k_d;
      base_q   <= base_d;
      wbuf_q   <= wbuf_d;
      rbuf_q   <= rbuf_d;
      mem_a    <= mem_a_d;
      mem_dout <= mem_dout_d;
      mem_wr   <= mem_wr_d;
      done     <= done_d;
      rdata    <= rdata_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: cycle-exact bus, done and rdata checks.
// Expected grant order follows MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter_n;
  localparam int NCH = 3;
  localparam int ADDR_W = 18;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     req, we, done;
  logic [2*NCH-1:0]   size;
  logic [32*NCH-1:0]  addr, wdata;
  logic [31:0]        rdata, mem_a;
  logic               busy, mem_wr;
  logic [7:0]         mem_din, mem_dout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_n #(.NCH(NCH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int c, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    we[c] = w;
    size[2*c +: 2] = s;
    addr[32*c +: 32] = a;
    wdata[32*c +: 32] = d;
    req[c] = 1'b1;
  endtask

  initial begin
    int first, second;
    int g[4];
    rst = 1'b0; req = '0; we = '0; size = '0; addr = '0; wdata = '0; mem_din = 8'h00;
    step(); step();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    step();

    // ch1 word read at 0x100
    setup(1, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
    step();                       // C1
    chk("wr_a0", mem_a, 32'h100); chk("wr_busy", 32'(busy), 32'h1); chk("wr_nowr", 32'(mem_wr), 32'h0);
    step(); mem_din = 8'h11;      // C2
    chk("wr_a1", mem_a, 32'h101);
    step(); mem_din = 8'h22;      // C3
    chk("wr_a2", mem_a, 32'h102);
    step(); mem_din = 8'h33;      // C4
    chk("wr_a3", mem_a, 32'h103);
    step(); mem_din = 8'h44;      // C5
    chk("wr_done_c5", 32'(done), 32'h0);
    step();                       // C6
    chk("wr_done", 32'(done), 32'h2); chk("wr_rdata", rdata, 32'h44332211);
    chk("wr_busy_done", 32'(busy), 32'h0);
    req[1] = 1'b0;
    step();
    chk("wr_done_clr", 32'(done), 32'h0);

    // ch0 half write at 0x200
    setup(0, 1'b1, 2'd1, 32'h0000_0200, 32'hAABBCCDD);
    step();
    chk("hw_wr1", 32'(mem_wr), 32'h1); chk("hw_a1", mem_a, 32'h200); chk("hw_d1", 32'(mem_dout), 32'hDD);
    step();
    chk("hw_wr2", 32'(mem_wr), 32'h1); chk("hw_a2", mem_a, 32'h201); chk("hw_d2", 32'(mem_dout), 32'hCC);
    step();
    chk("hw_done", 32'(done), 32'h1); chk("hw_wr3", 32'(mem_wr), 32'h0);
    req[0] = 1'b0;
    step();
    chk("hw_wr4", 32'(mem_wr), 32'h0); chk("hw_done_clr", 32'(done), 32'h0);

    // ch0 and ch2 byte reads together
    first  = RR ? 2 : 0;
    second = RR ? 0 : 2;
    setup(0, 1'b0, 2'd0, 32'h0000_0300, 32'h0);
    setup(2, 1'b0, 2'd0, 32'h0000_0400, 32'h0);
    step();
    chk("pr_a_first", mem_a, (first == 0) ? 32'h300 : 32'h400);
    step(); mem_din = 8'h5A;
    step();                       // C3
    chk("pr_done_first", 32'(done), 32'(1 << first)); chk("pr_rdata_first", rdata, 32'h5A);
    req[first] = 1'b0;
    step();                       // C4 = second C1
    chk("pr_a_second", mem_a, (second == 0) ? 32'h300 : 32'h400); chk("pr_done_c4", 32'(done), 32'h0);
    step(); mem_din = 8'hA5;
    step();                       // C6
    chk("pr_done_second", 32'(done), 32'(1 << second)); chk("pr_rdata_second", rdata, 32'hA5);
    req[second] = 1'b0;
    step();

    // word read across the ADDR_W wrap, upper address bits ignored
    setup(1, 1'b0, 2'd3, 32'h0013_FFFE, 32'h0);
    step(); chk("wrap_a0", mem_a, 32'h3FFFE);
    step(); chk("wrap_a1", mem_a, 32'h3FFFF); mem_din = 8'h01;
    step(); chk("wrap_a2", mem_a, 32'h00000); mem_din = 8'h02;
    step(); chk("wrap_a3", mem_a, 32'h00001); mem_din = 8'h03;
    step(); mem_din = 8'h04;
    step(); chk("wrap_done", 32'(done), 32'h2); chk("wrap_rdata", rdata, 32'h04030201);
    req[1] = 1'b0;
    step();

    // reset in C2 of a word write
    setup(2, 1'b1, 2'd2, 32'h0000_0500, 32'h01020304);
    step(); chk("rs_wr1", 32'(mem_wr), 32'h1); chk("rs_d1", 32'(mem_dout), 32'h04);
    step(); chk("rs_wr2", 32'(mem_wr), 32'h1); chk("rs_d2", 32'(mem_dout), 32'h03);
    rst = 1'b0;
    #1;
    chk("rs_wr_now", 32'(mem_wr), 32'h0); chk("rs_busy_now", 32'(busy), 32'h0);
    chk("rs_done_now", 32'(done), 32'h0);
    req[2] = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rs_idle_done", 32'(done), 32'h0);
    setup(0, 1'b1, 2'd0, 32'h0000_0600, 32'h0000_0077);
    step();
    chk("rs_new_wr", 32'(mem_wr), 32'h1); chk("rs_new_a", mem_a, 32'h600);
    chk("rs_new_d", 32'(mem_dout), 32'h77); chk("rs_new_nodone", 32'(done), 32'h0);
    step();
    chk("rs_new_done", 32'(done), 32'h1);
    req[0] = 1'b0;
    step();

    // all channels held continuously, byte writes; fresh reset sets pointer to NCH-1
    rst = 1'b0; step(); rst = 1'b1; step();
    if (RR) g = '{0, 1, 2, 0};
    else    g = '{0, 1, 0, 1};
    for (int c = 0; c < NCH; c++) setup(c, 1'b1, 2'd0, 32'h700 + c, 32'hC0 + c);
    for (int t = 0; t < 4; t++) begin
      step();
      chk($sformatf("cont_a%0d", t), mem_a, 32'h700 + g[t]);
      chk($sformatf("cont_wr%0d", t), 32'(mem_wr), 32'h1);
      chk($sformatf("cont_d%0d", t), 32'(mem_dout), 32'hC0 + g[t]);
      step();
      chk($sformatf("cont_done%0d", t), 32'(done), 32'(1 << g[t]));
    end
    req = '0;
    step();
    chk("cont_idle_busy", 32'(busy), 32'h0); chk("cont_idle_wr", 32'(mem_wr), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_n.md
# mem_arbiter_n

Parametrised multi-channel memory arbiter and byte-serial sequencer for the RISCV32I core. It accepts up to `NCH` independent load/store/fetch request channels, grants one at a time, and serialises each 1/2/4-byte little-endian transfer onto the 8-bit external memory bus. It supersedes the fixed three-port controller between the pipeline stages (IF, MEM read, MEM write) and `mem_din`/`mem_dout`/`mem_a`/`mem_wr`.

## Interface
- `NCH`, 3: number of request channels (≥2); channel 0 is the highest fixed priority.
- `ADDR_W`, 18: significant address bits; `mem_a[31:ADDR_W]` driven 0.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in NCH: per-channel request level; held until that channel's `done`.
- `we` in NCH: 1 = write, 0 = read.
- `size` in 2*NCH: per channel, 0 = byte, 1 = half, 2/3 = word.
- `addr` in 32*NCH: per-channel start byte address.
- `wdata` in 32*NCH: per-channel write data, byte k in bits [8k+7:8k].
- `rdata` out 32: read result of the channel pulsing `done`; untransferred bytes 0.
- `done` out NCH: one-cycle completion pulse, one-hot or zero.
- `busy` out 1: high whenever the state is not IDLE.
- `mem_din` in 8: memory read byte.
- `mem_dout` out 8: memory write byte.
- `mem_a` out 32: memory byte address.
- `mem_wr` out 1: 1 = write.

## Operation
- States: IDLE, ADDR, TAIL. Byte count n = 1/2/4 from `size`.
- IDLE: if any eligible `req`, grant by policy (see Configuration); latch channel, `we`, n, address, wdata; go ADDR with byte index k=0. A channel whose `done` is high this cycle is ineligible.
- ADDR: `mem_a` = (addr+k) mod 2^ADDR_W. Write: `mem_wr`=1, `mem_dout` = byte k. Read: `mem_wr`=0; for k≥1, capture `mem_din` into byte k-1. At k=n-1: write → IDLE with `done` pulse; read → TAIL.
- TAIL (read only): capture `mem_din` into byte n-1, `mem_wr`=0 → IDLE with `done` pulse and final `rdata`.
- Address increment wraps within ADDR_W bits (e.g. 0x3FFFF → 0x00000 for ADDR_W=18).
- Requests arriving mid-transfer wait; no preemption; latched fields are immune to input changes after grant.
- All outputs registered.

## Timing
- Reset values: state IDLE, `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `done`=0, `rdata`=0, `busy`=0, round-robin pointer = NCH-1.
- C0 = IDLE cycle in which grant is decided. `mem_a` carries byte k address in cycle C(k+1); memory returns that byte in C(k+2).
- Write of n bytes: `mem_wr`=1 in C1..Cn, `done` in C(n+1). Word write: done at C5.
- Read of n bytes: capture at end of C2..C(n+1), `done` + `rdata` in C(n+2). Byte read: done at C3; word read: done at C6.
- `done` cycle is an IDLE cycle: a different channel may be granted in it (back-to-back, no bubble); requester must deassert `req` in its `done` cycle.
- `rst` asserted mid-transfer: immediately IDLE, `mem_wr`=0, no `done`; transfer abandoned (partial bytes of a write may have landed).

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin; search starts at pointer+1 modulo NCH, pointer updated to granted channel at each grant.
- Undefined: fixed priority, lowest eligible index wins; pointer logic absent.

## Test plan
- Reset then channel 1 word read at 0x00100, memory bytes 11,22,33,44 → `mem_a` 0x100..0x103 in C1..C4, `done`[1] at C6, `rdata`=0x44332211.
- Channel 0 half write addr 0x00200 wdata 0xAABBCCDD → `mem_wr`=1 C1..C2, bytes DD then CC, `done`[0] at C3, no other bus write.
- Channels 0 and 2 request simultaneously, byte reads: fixed priority → ch0 done C3, ch2 granted in C3, done C6; with `MEM_ARB_RR_EN` after prior ch0 grant → ch2 first.
- Word read at 0x3FFFE (ADDR_W=18) → `mem_a` 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- `rst` low in C2 of a word write → `mem_wr`=0 and `busy`=0 immediately; no `done`; next request starts cleanly from C0.
- All three channels held requesting continuously under round-robin → grants 0,1,2,0 with no idle cycles between transfers.
